// File: rtl/serial_paralelo_pkg.sv
// rtl/serial_paralelo_pkg.sv - shared comma constant and state encoding for the RX deserializer
package serial_paralelo_pkg;

    // Idle/alignment byte the transmitter sends when it has no valid data
    localparam logic [7:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_paralelo_comma_detect.sv
// rtl/serial_paralelo_comma_detect.sv - combinational comma byte compare, shared with the loopback checker
module serial_paralelo_comma_detect
    import serial_paralelo_pkg::*;
#(
    parameter logic [7:0] PATTERN = COMMA
) (
    input  logic [7:0] byte_in,
    output logic       hit
);

    assign hit = (byte_in == PATTERN);

endmodule

// File: rtl/serial_paralelo.sv
// rtl/serial_paralelo.sv - serial-to-parallel deserializer with comma alignment; optional SERIAL_PARALELO_IDLE_CNT_EN adds idle_count
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter int BC_LOCK = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
    ,
    output logic [7:0] idle_count
`endif
);

    // Commas needed to lock, counting the first hit found while hunting
    localparam logic [4:0] LOCK_CNT = 5'(BC_LOCK);

    state_t     state;
    state_t     state_n;
    logic [7:0] shift_reg;
    logic [7:0] nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_n;
    logic [3:0] bc_cnt;
    logic [3:0] bc_cnt_n;
    logic [7:0] data_out_n;
    logic       valid_out_n;
    logic       active_n;
    logic       is_comma;
    logic       boundary;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
    logic [7:0] idle_count_n;
`endif

    // The byte as it will look once this cycle's bit is shifted in
    assign nxt      = {shift_reg[6:0], data_in};
    assign boundary = (bit_cnt == 3'd7);

    serial_paralelo_comma_detect #(
        .PATTERN(COMMA)
    ) u_comma_detect (
        .byte_in(nxt),
        .hit    (is_comma)
    );

    // State register
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: shifter, byte phase, comma run length and outputs
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            bc_cnt     <= 4'd0;
            data_out   <= 8'h00;
            valid_out  <= 1'b0;
            active     <= 1'b0;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
            idle_count <= 8'h00;
`endif
        end else begin
            shift_reg  <= nxt;
            bit_cnt    <= bit_cnt_n;
            bc_cnt     <= bc_cnt_n;
            data_out   <= data_out_n;
            valid_out  <= valid_out_n;
            active     <= active_n;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
            idle_count <= idle_count_n;
`endif
        end
    end

    // Next-state and next-output decode; outputs only move at byte boundaries
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt + 3'd1;
        bc_cnt_n    = bc_cnt;
        data_out_n  = data_out;
        valid_out_n = valid_out;
        active_n    = active;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
        idle_count_n = idle_count;
`endif

        case (state)
            SEARCH: begin
                // No byte phase yet: hold the counter until a comma appears at any offset
                bit_cnt_n = bit_cnt;
                if (is_comma) begin
                    bit_cnt_n = 3'd0;
                    bc_cnt_n  = 4'd1;
                    if (LOCK_CNT == 5'd1) begin
                        state_n  = ACTIVE;
                        active_n = 1'b1;
                    end else begin
                        state_n = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_n = bc_cnt + 4'd1;
                        if (({1'b0, bc_cnt} + 5'd1) == LOCK_CNT) begin
                            state_n  = ACTIVE;
                            active_n = 1'b1;
                        end
                    end else begin
                        // Broken comma run: the phase guess was wrong, hunt again
                        bc_cnt_n = 4'd0;
                        state_n  = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                // Locked until reset; misalignment is deliberately not tracked
                if (boundary) begin
                    if (is_comma) begin
                        valid_out_n = 1'b0;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
                        if (idle_count != 8'hFF) begin
                            idle_count_n = idle_count + 8'd1;
                        end
`endif
                    end else begin
                        data_out_n  = nxt;
                        valid_out_n = 1'b1;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
                        idle_count_n = 8'h00;
`endif
                    end
                end
            end

            default: begin
                state_n   = SEARCH;
                bit_cnt_n = 3'd0;
                bc_cnt_n  = 4'd0;
            end
        endcase
    end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
Receive-side counterpart of the PHY TX serializer: a serial-to-parallel deserializer with comma alignment. It takes the 1-bit MSB-first stream at clk_32f and hunts for the 8'hBC idle/comma byte to find byte boundaries. Once a configurable number of consecutive aligned commas has been seen, it declares lock. From then on it emits each non-comma byte with a valid flag. It sits in the PHY RX path, ahead of the byte-level consumers.

Parameters:
COMMA, 8'hBC, idle/alignment byte the transmitter sends when it has no valid data
BC_LOCK, 4, number of consecutive aligned COMMA bytes (counting the first hit) required to enter ACTIVE; legal range 1..15

Ports:
clk_32f  input  1  bit clock; all logic on posedge
reset  input  1  synchronous, active-high reset
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last received non-comma byte
valid_out  output  1  high for the byte period following reception of a non-comma byte while ACTIVE
active  output  1  high while in ACTIVE (byte lock)

Behaviour:
- Clock and reset: one clock, clk_32f. Reset is synchronous and active-high.
- Reset values: data_out=8'h00, valid_out=0, active=0, shift_reg=0, bit_cnt=0, bc_cnt=0, state=SEARCH. Reset mid-stream discards all alignment; the next COMMA hunt starts from scratch.
- Shift register: every cycle, shift_reg <= {shift_reg[6:0], data_in}. Define nxt = {shift_reg[6:0], data_in}.
- State SEARCH:
  - Each cycle, compare nxt against COMMA at any bit phase.
  - On match: bit_cnt<=0 and bc_cnt<=1. Go to ACTIVE if BC_LOCK==1, otherwise go to ALIGN.
- bit_cnt, in ALIGN and ACTIVE:
  - Increments every cycle and wraps 7->0.
  - The cycle with bit_cnt==7 is the byte boundary; nxt is the complete byte.
- State ALIGN, at each boundary:
  - nxt==COMMA: bc_cnt++. If bc_cnt+1==BC_LOCK, go to ACTIVE.
  - nxt!=COMMA: bc_cnt<=0, go to SEARCH.
- State ACTIVE, at each boundary:
  - nxt!=COMMA: data_out<=nxt, valid_out<=1.
  - nxt==COMMA: valid_out<=0, data_out holds.
- ACTIVE is sticky until reset; misalignment is not detected.
- Output timing:
  - active and valid_out are registered and change only at boundaries, or on the SEARCH->ACTIVE transition when BC_LOCK==1.
  - Latency: last bit of a byte is sampled at edge N; data_out/valid_out show that byte after edge N and hold for 8 cycles.
- Bytes received before ACTIVE are never output; valid_out stays 0.
- bc_cnt is 4 bits and cannot overflow given the BC_LOCK range.

Optional Feature:
Macro SERIAL_PARALELO_IDLE_CNT_EN.
- Defined: adds output idle_count[7:0], reset 0.
  - Increments at each ACTIVE boundary whose byte is COMMA.
  - Saturates at 8'hFF.
  - Clears to 0 at each ACTIVE boundary whose byte is non-comma.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include: COMMA constant; state encoding SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2.
- Optional sub-module comma_detect: combinational nxt==COMMA compare, reused by the TX/RX loopback checker.
- Everything else stays flat in serial_paralelo.

Test Plan:
1. Reset held 3 cycles, then released with data_in=0 -> data_out=00, valid_out=0, active=0 throughout.
2. 4x BC then A5, 3C, MSB first, BC_LOCK=4 -> active rises at the 4th BC boundary; data_out=A5 with valid_out=1 for 8 cycles, then 3C.
3. 3 junk bits (1,0,1) precede 4x BC then 5A -> lock found at bit offset 3; data_out=5A, valid_out=1.
4. BC, BC, 7E, then 4x BC, 11 -> after 7E returns to SEARCH, active=0; relocks on the second BC group; outputs only 11.
5. In ACTIVE: 22, BC, BC, 33 -> valid_out 1,0,0,1 per byte period; data_out holds 22 during the BCs. With SERIAL_PARALELO_IDLE_CNT_EN, idle_count goes 0,1,2,0.
6. Reset asserted mid-byte while ACTIVE -> next cycle active=0, valid_out=0, data_out=00; 4 further BCs are required to relock.
